// File: rtl/vga_pkg.sv
// Shared framebuffer constants and enums for the VGA text writer and its font ROM.
package vga_pkg;

  localparam int FB_COLS   = 80;
  localparam int FB_WORD_W = 32;
  localparam int FB_ADDR_W = 13;
  localparam int CHAR_H    = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WR_TOP,
    WR_BOT,
    CLEAR,
    FIN
  } text_wr_state_t;

  typedef enum logic {
    CMD_CHAR  = 1'b0,
    CMD_CLEAR = 1'b1
  } text_cmd_t;

endpackage

// File: rtl/font8x8_rom.sv
// 8x8 glyph ROM, one registered 64-bit read per cycle, packed {g7..g0}, bit 0 = leftmost pixel.
// Only a few real glyphs are populated; any other code renders a hollow box outline.
module font8x8_rom
  import vga_pkg::*;
(
  input  logic                  clk,
  input  logic [7:0]            char_code,
  output logic [CHAR_H*8-1:0]   glyph
);

  always_ff @(posedge clk) begin
    case (char_code)
      8'h00, 8'h20: glyph <= 64'h0000_0000_0000_0000;
      8'h30:        glyph <= 64'h003E_676F_7B73_633E;
      8'h41:        glyph <= 64'h0033_333F_3333_1E0C;
      8'h48:        glyph <= 64'h0033_3333_3F33_3333;
      default:      glyph <= 64'hFF81_8181_8181_81FF;
    endcase
  end

endmodule

// File: rtl/vga_text_writer.sv
// Turns draw-char / clear-screen commands into held word writes on the framebuffer port.
//   state  | meaning
//   IDLE   | waiting for a command (req_ready high)
//   FETCH  | glyph read from the font ROM
//   WR_TOP | writing glyph lines 0-3
//   WR_BOT | writing glyph lines 4-7
//   CLEAR  | filling every word with the fill byte
//   FIN    | emits done/err, then returns to IDLE
module vga_text_writer
  import vga_pkg::*;
#(
  parameter int COLS       = 80,
  parameter int MAX_ROW    = 51,
  parameter int ADDR_DEPTH = 8192,
  parameter int WR_HOLD    = 2
) (
  input  logic                 CLK_50,
  input  logic                 Reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_cmd,
  input  logic [6:0]           req_col,
  input  logic [5:0]           req_row,
  input  logic [7:0]           req_char,
  input  logic                 req_inv,
  output logic [FB_WORD_W-1:0] WrData,
  output logic [FB_ADDR_W-1:0] WrAddress,
  output logic                 WrEn,
  output logic                 done,
  output logic                 err
);

  localparam int HOLD_W = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;
  localparam logic [HOLD_W-1:0]    HOLD_LOAD = HOLD_W'(WR_HOLD - 1);
  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(ADDR_DEPTH - 1);
  localparam logic [6:0]           COLS_L    = 7'(COLS);
  localparam logic [5:0]           ROWS_L    = 6'(MAX_ROW);

  text_wr_state_t         state;
  logic [6:0]             cap_col;
  logic [5:0]             cap_row;
  logic [7:0]             cap_char;
  logic                   cap_inv;
  logic                   cap_err;
  logic [FB_ADDR_W-1:0]   cnt;
  logic [HOLD_W-1:0]      tmr;
  logic [CHAR_H*8-1:0]    glyph;
  logic [FB_ADDR_W-1:0]   top_addr;
  logic [FB_ADDR_W-1:0]   bot_addr;
  logic [FB_WORD_W-1:0]   inv_mask;
  logic [FB_WORD_W-1:0]   top_data;
  logic [FB_WORD_W-1:0]   bot_data;

  font8x8_rom u_rom (
    .clk       (CLK_50),
    .char_code (cap_char),
    .glyph     (glyph)
  );

  assign req_ready = (state == IDLE) && !Reset;

  // Each character row spans two framebuffer word rows.
  assign top_addr = FB_ADDR_W'(cap_row) * FB_ADDR_W'(2 * FB_COLS) + FB_ADDR_W'(cap_col);
  assign bot_addr = top_addr + FB_ADDR_W'(FB_COLS);
  assign inv_mask = {FB_WORD_W{cap_inv}};
  assign top_data = glyph[31:0]  ^ inv_mask;
  assign bot_data = glyph[63:32] ^ inv_mask;

  always_ff @(posedge CLK_50) begin
    if (Reset) begin
      state     <= IDLE;
      WrEn      <= 1'b0;
      WrData    <= '0;
      WrAddress <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      cap_col   <= '0;
      cap_row   <= '0;
      cap_char  <= '0;
      cap_inv   <= 1'b0;
      cap_err   <= 1'b0;
      cnt       <= '0;
      tmr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (req_valid && req_ready) begin
            cap_col  <= req_col;
            cap_row  <= req_row;
            cap_char <= req_char;
            cap_inv  <= req_inv;
            cnt      <= '0;
            tmr      <= HOLD_LOAD;
            if (text_cmd_t'(req_cmd) == CMD_CLEAR) begin
              cap_err <= 1'b0;
              state   <= CLEAR;
            end else if (req_col < COLS_L && req_row < ROWS_L) begin
              cap_err <= 1'b0;
              state   <= FETCH;
            end else begin
              cap_err <= 1'b1;
              state   <= FIN;
            end
          end
        end
        FETCH: state <= WR_TOP;
        WR_TOP: begin
          WrEn      <= 1'b1;
          WrAddress <= top_addr;
          WrData    <= top_data;
          if (tmr == '0) begin
            tmr   <= HOLD_LOAD;
            state <= WR_BOT;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        WR_BOT: begin
          WrEn      <= 1'b1;
          WrAddress <= bot_addr;
          WrData    <= bot_data;
          if (tmr == '0) state <= FIN;
          else           tmr   <= tmr - 1'b1;
        end
        CLEAR: begin
          WrEn      <= 1'b1;
          WrAddress <= cnt;
          WrData    <= {4{cap_char}};
          if (tmr == '0) begin
            tmr <= HOLD_LOAD;
            if (cnt == LAST_ADDR) state <= FIN;
            else                  cnt   <= cnt + 1'b1;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        FIN: begin
          // Two phases: pulse done/err, then release to IDLE.
          WrEn <= 1'b0;
          if (!done) begin
            done <= 1'b1;
            err  <= cap_err;
          end else begin
            done  <= 1'b0;
            err   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_text_writer.sv
// Directed bench for vga_text_writer: table of draw vectors plus clear, busy and reset sequences.
module tb_vga_text_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_cmd;
  logic [6:0]  req_col;
  logic [5:0]  req_row;
  logic [7:0]  req_char;
  logic        req_inv;
  logic [31:0] wr_data;
  logic [12:0] wr_addr;
  logic        wr_en;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [6:0]  col;
    logic [5:0]  row;
    logic [7:0]  ch;
    logic        inv;
    logic        bad;
    logic [12:0] ta;
    logic [31:0] td;
    logic [12:0] ba;
    logic [31:0] bd;
  } vec_t;

  vec_t vecs[8];

  vga_text_writer dut (
    .CLK_50    (clk),
    .Reset     (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_col   (req_col),
    .req_row   (req_row),
    .req_char  (req_char),
    .req_inv   (req_inv),
    .WrData    (wr_data),
    .WrAddress (wr_addr),
    .WrEn      (wr_en),
    .done      (done),
    .err       (err)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Call right after the accept edge; checks edges T+1..T+7.
  task automatic check_draw_seq(input string p, input logic [12:0] ta, input logic [31:0] td,
                                input logic [12:0] ba, input logic [31:0] bd);
    for (int k = 1; k <= 7; k++) begin
      tick();
      case (k)
        1: begin
          chk($sformatf("%s_k1_wren", p), 32'(wr_en), 0);
          chk($sformatf("%s_k1_done", p), 32'(done), 0);
        end
        2, 3: begin
          chk($sformatf("%s_k%0d_wren", p, k), 32'(wr_en), 1);
          chk($sformatf("%s_k%0d_addr", p, k), 32'(wr_addr), 32'(ta));
          chk($sformatf("%s_k%0d_data", p, k), wr_data, td);
          chk($sformatf("%s_k%0d_done", p, k), 32'(done), 0);
        end
        4, 5: begin
          chk($sformatf("%s_k%0d_wren", p, k), 32'(wr_en), 1);
          chk($sformatf("%s_k%0d_addr", p, k), 32'(wr_addr), 32'(ba));
          chk($sformatf("%s_k%0d_data", p, k), wr_data, bd);
        end
        6: begin
          chk($sformatf("%s_k6_wren", p), 32'(wr_en), 0);
          chk($sformatf("%s_k6_done", p), 32'(done), 1);
          chk($sformatf("%s_k6_err", p), 32'(err), 0);
          chk($sformatf("%s_k6_ready", p), 32'(req_ready), 0);
        end
        default: begin
          chk($sformatf("%s_k7_done", p), 32'(done), 0);
          chk($sformatf("%s_k7_ready", p), 32'(req_ready), 1);
        end
      endcase
    end
  endtask

  task automatic check_err_seq(input string p);
    tick();
    chk($sformatf("%s_e1_wren", p), 32'(wr_en), 0);
    chk($sformatf("%s_e1_done", p), 32'(done), 1);
    chk($sformatf("%s_e1_err", p), 32'(err), 1);
    chk($sformatf("%s_e1_ready", p), 32'(req_ready), 0);
    tick();
    chk($sformatf("%s_e2_wren", p), 32'(wr_en), 0);
    chk($sformatf("%s_e2_done", p), 32'(done), 0);
    chk($sformatf("%s_e2_ready", p), 32'(req_ready), 1);
  endtask

  task automatic apply_vec(input int i);
    string p;
    p = $sformatf("v%0d", i);
    chk({p, "_ready_pre"}, 32'(req_ready), 1);
    req_cmd   = 1'b0;
    req_col   = vecs[i].col;
    req_row   = vecs[i].row;
    req_char  = vecs[i].ch;
    req_inv   = vecs[i].inv;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_cmd   = 1'b1;
    req_char  = ~vecs[i].ch;
    req_col   = vecs[i].col + 7'd3;
    req_inv   = ~vecs[i].inv;
    if (vecs[i].bad) check_err_seq(p);
    else check_draw_seq(p, vecs[i].ta, vecs[i].td, vecs[i].ba, vecs[i].bd);
  endtask

  initial begin
    int bad_stream;
    int done_seen;
    int wren_seen;
    bit found;

    //           col     row    ch     inv   bad   top      top data       bot      bot data
    vecs[0] = '{7'd0,   6'd0,  8'h41, 1'b0, 1'b0, 13'd0,    32'h33331E0C, 13'd80,   32'h0033333F};
    vecs[1] = '{7'd79,  6'd50, 8'h48, 1'b1, 1'b0, 13'd8079, 32'hC0CCCCCC, 13'd8159, 32'hFFCCCCCC};
    vecs[2] = '{7'd5,   6'd3,  8'h30, 1'b0, 1'b0, 13'd485,  32'h7B73633E, 13'd565,  32'h003E676F};
    vecs[3] = '{7'd10,  6'd1,  8'h7E, 1'b1, 1'b0, 13'd170,  32'h7E7E7E00, 13'd250,  32'h007E7E7E};
    vecs[4] = '{7'd80,  6'd0,  8'h41, 1'b0, 1'b1, 13'd0,    32'h0,        13'd0,    32'h0};
    vecs[5] = '{7'd0,   6'd51, 8'h41, 1'b0, 1'b1, 13'd0,    32'h0,        13'd0,    32'h0};
    vecs[6] = '{7'd127, 6'd63, 8'h48, 1'b1, 1'b1, 13'd0,    32'h0,        13'd0,    32'h0};
    vecs[7] = '{7'd0,   6'd50, 8'h20, 1'b0, 1'b0, 13'd8000, 32'h00000000, 13'd8080, 32'h00000000};

    rst = 1'b1; req_valid = 1'b0; req_cmd = 1'b0; req_col = '0; req_row = '0;
    req_char = '0; req_inv = 1'b0;
    tick();
    tick();
    chk("rst_wren",  32'(wr_en), 0);
    chk("rst_data",  wr_data, 0);
    chk("rst_addr",  32'(wr_addr), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_err",   32'(err), 0);
    chk("rst_ready", 32'(req_ready), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 1);

    for (int i = 0; i < 8; i++) apply_vec(i);

    // req_valid held high while busy: second command waits for the first to finish.
    req_cmd = 1'b0; req_col = 7'd2; req_row = 6'd2; req_char = 8'h41; req_inv = 1'b0;
    req_valid = 1'b1;
    tick();
    req_col = 7'd3; req_row = 6'd0; req_char = 8'h48;
    check_draw_seq("busy_a", 13'd322, 32'h33331E0C, 13'd402, 32'h0033333F);
    tick();
    req_valid = 1'b0;
    check_draw_seq("busy_h", 13'd3, 32'h3F333333, 13'd83, 32'h00333333);

    // Full clear with fill 0xAA.
    req_cmd = 1'b1; req_char = 8'hAA; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; req_char = 8'h00; req_cmd = 1'b0;
    bad_stream = 0;
    for (int i = 0; i < 16384; i++) begin
      tick();
      if (wr_en !== 1'b1 || wr_addr !== 13'(i / 2) || wr_data !== 32'hAAAAAAAA || done !== 1'b0) begin
        if (bad_stream < 4)
          $display("FAIL clear_beat_%0d: got en=%b addr=%0d data=%h done=%b expected en=1 addr=%0d data=aaaaaaaa done=0",
                   i, wr_en, wr_addr, wr_data, done, i / 2);
        bad_stream++;
      end
    end
    chk("clear_stream_errs", 32'(bad_stream), 0);
    tick();
    chk("clear_end_wren", 32'(wr_en), 0);
    chk("clear_end_done", 32'(done), 1);
    chk("clear_end_err",  32'(err), 0);
    tick();
    chk("clear_post_done",  32'(done), 0);
    chk("clear_post_ready", 32'(req_ready), 1);

    // Reset in the middle of a clear.
    req_cmd = 1'b1; req_char = 8'h55; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      tick();
      if (wr_en === 1'b1 && wr_addr === 13'd100) found = 1'b1;
    end
    chk("rstmid_reach_addr100", 32'(found), 1);
    rst = 1'b1;
    #1;
    chk("rstmid_ready_in_rst", 32'(req_ready), 0);
    tick();
    chk("rstmid_wren", 32'(wr_en), 0);
    chk("rstmid_done", 32'(done), 0);
    chk("rstmid_err",  32'(err), 0);
    rst = 1'b0;
    #1;
    chk("rstmid_ready_after", 32'(req_ready), 1);
    done_seen = 0;
    wren_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) done_seen++;
      if (wr_en === 1'b1) wren_seen++;
    end
    chk("rstmid_no_done", 32'(done_seen), 0);
    chk("rstmid_no_wren", 32'(wren_seen), 0);

    apply_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
